// File: rtl/aap_pkg.sv
// Shared definitions for the AAP pipeline: default parameters, instruction
// length encoding and the halfword filler used when assembling short instructions.
package aap_pkg;

    localparam int PC_WIDTH_DEFAULT = 24;
    localparam int RESET_PC_DEFAULT = 0;
    localparam int INSN_LONG_BIT    = 15;

    typedef logic [15:0] half_t;

    localparam half_t HALF_NOP = 16'h0000;

    function automatic logic is_long(input half_t halfword);
        return halfword[INSN_LONG_BIT];
    endfunction

endpackage

// File: rtl/aap_halfword_fifo.sv
// Prefetch buffer of halfwords with their addresses. Entry 0 is always the head;
// pops shift the contents down so the two oldest halfwords are directly readable.
module aap_halfword_fifo
    import aap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  half_t         push_data,
    input  logic [AW-1:0] push_addr,
    input  logic          pop1,
    input  logic          pop2,
    input  logic          flush,
    output half_t         head0_data,
    output logic [AW-1:0] head0_addr,
    output half_t         head1_data,
    output logic [CW-1:0] count
);

    localparam int IW = $clog2(DEPTH);

    half_t         data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    half_t         data_n [DEPTH];
    logic [AW-1:0] addr_n [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_n;
    logic [CW-1:0] npop;
    logic [CW-1:0] wr_idx;

    always_comb begin
        npop = pop2 ? CW'(2) : (pop1 ? CW'(1) : CW'(0));
        data_n = data_q;
        addr_n = addr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (i + int'(npop) < DEPTH) begin
                data_n[i] = data_q[IW'(i + int'(npop))];
                addr_n[i] = addr_q[IW'(i + int'(npop))];
            end
        end
        // The incoming halfword lands just behind whatever survives the pop.
        wr_idx = count_q - npop;
        if (push) begin
            data_n[IW'(wr_idx)] = push_data;
            addr_n[IW'(wr_idx)] = push_addr;
        end
        count_n = count_q - npop + CW'(push);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_n;
            data_q  <= data_n;
            addr_q  <= addr_n;
        end
    end

    assign head0_data = data_q[0];
    assign head0_addr = addr_q[0];
    assign head1_data = data_q[1];
    assign count      = count_q;

endmodule

// File: rtl/aap_fetch_unit.sv
// AAP instruction fetch: streams halfwords from a one-cycle synchronous memory into a
// prefetch buffer and assembles 16/32-bit instructions for the decoder.
module aap_fetch_unit
    import aap_pkg::*;
#(
    parameter int                  PC_WIDTH  = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int                  BUF_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                stall,
    output logic [31:0]         fetchoutput,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] fetch_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_addr_q;
    logic                inflight_q;
    logic                kill_q;

    logic                push;
    logic                pop1;
    logic                pop2;
    half_t               head0_data;
    half_t               head1_data;
    logic [PC_WIDTH-1:0] head0_addr;
    logic [CW-1:0]       count;
    logic [CW:0]         occupancy;
    logic                head_long;
    logic                insn_ready;

    aap_halfword_fifo #(
        .DEPTH (BUF_DEPTH),
        .AW    (PC_WIDTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (imem_rdata),
        .push_addr  (req_addr_q),
        .pop1       (pop1),
        .pop2       (pop2),
        .flush      (branch_taken),
        .head0_data (head0_data),
        .head0_addr (head0_addr),
        .head1_data (head1_data),
        .count      (count)
    );

    // Slots already promised to the in-flight read count as occupied, so a
    // returning halfword always has room.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight_q);
    assign imem_req  = !reset && !branch_taken && (occupancy < (CW + 1)'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign push      = inflight_q && !kill_q && !branch_taken;

    // Handshake: an instruction transfers on every cycle where fetch_valid is high
    // and stall is low; fetch_valid never looks at stall, only a branch forces it low.
    assign head_long   = is_long(head0_data);
    assign insn_ready  = head_long ? (count > CW'(1)) : (count != '0);
    assign fetchoutput = insn_ready ? {head0_data, head_long ? head1_data : HALF_NOP} : 32'h0;
    assign fetch_valid = insn_ready && !branch_taken;
    assign fetch_pc    = (count != '0) ? head0_addr : '0;
    assign pop1        = fetch_valid && !stall && !head_long;
    assign pop2        = fetch_valid && !stall && head_long;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (branch_taken) begin
                pc_q   <= branch_target;
                kill_q <= inflight_q;
            end else begin
                kill_q <= 1'b0;
                if (imem_req) begin
                    pc_q       <= pc_q + PC_WIDTH'(1);
                    req_addr_q <= pc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_aap_fetch_unit.sv
// Directed bench for aap_fetch_unit: a scoreboard queue of accepted instructions
// plus cycle-exact checks on startup, stall back-pressure, branches and reset.
module tb_aap_fetch_unit;

    localparam int PCW = 24;
    localparam int W   = 32 + PCW;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            branch_taken = 1'b0;
    logic            stall = 1'b0;
    logic [PCW-1:0]  branch_target = '0;
    logic [15:0]     imem_rdata = '0;
    logic            imem_req;
    logic [PCW-1:0]  imem_addr;
    logic [31:0]     fetchoutput;
    logic            fetch_valid;
    logic [PCW-1:0]  fetch_pc;

    logic            w_req;
    logic [PCW-1:0]  w_addr;
    logic [31:0]     w_out;
    logic            w_valid;
    logic [PCW-1:0]  w_pc;

    logic [15:0]     mem [512];
    logic [W-1:0]    exp_q [$];
    logic [W-1:0]    mon_e;
    int              n_cmp = 0;
    int              n_err = 0;

    // clock / reset
    always #5 clock = ~clock;

    aap_fetch_unit #(.PC_WIDTH(PCW), .RESET_PC(24'h000000), .BUF_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .fetchoutput   (fetchoutput),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc)
    );

    aap_fetch_unit #(.PC_WIDTH(PCW), .RESET_PC(24'hFFFFFF), .BUF_DEPTH(4)) dut_wrap (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_rdata    (16'h0000),
        .branch_taken  (1'b0),
        .branch_target (24'h000000),
        .stall         (1'b0),
        .fetchoutput   (w_out),
        .fetch_valid   (w_valid),
        .fetch_pc      (w_pc)
    );

    // synchronous instruction memory, one-cycle read latency
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= mem[imem_addr[8:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && fetch_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_insn: got %h at pc %h, nothing expected", fetchoutput, fetch_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("scoreboard", 64'({fetchoutput, fetch_pc}), 64'(mon_e));
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] word, input logic [PCW-1:0] pc);
        exp_q.push_back({word, pc});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    // Leaves the bench at the start of cycle C (first cycle with reset low).
    task automatic do_reset(input logic st);
        next_cycle();
        reset = 1'b1;
        branch_taken = 1'b0;
        stall = st;
        @(posedge clock);
        @(negedge clock);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_valid", 64'(fetch_valid), 64'd0);
        check("reset_out", 64'(fetchoutput), 64'd0);
        check("reset_pc", 64'(fetch_pc), 64'd0);
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            #1;
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d instructions still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        next_cycle();
        stall = 1'b1;
    endtask

    initial begin
        clear_mem();

        // short instructions, startup timing and PC wrap on the second instance
        mem[0] = 16'h1234;
        mem[1] = 16'h0042;
        exp_push(32'h12340000, 24'h0);
        exp_push(32'h00420000, 24'h1);
        do_reset(1'b0);
        @(negedge clock);
        check("c_req", 64'(imem_req), 64'd1);
        check("c_addr", 64'(imem_addr), 64'd0);
        check("c_valid", 64'(fetch_valid), 64'd0);
        check("wrap_c_req", 64'(w_req), 64'd1);
        check("wrap_c_addr", 64'(w_addr), 64'hFFFFFF);
        check("wrap_c_valid", 64'({w_valid, w_out, w_pc}), 64'd0);
        @(negedge clock);
        check("c1_valid", 64'(fetch_valid), 64'd0);
        check("wrap_c1_addr", 64'(w_addr), 64'd0);
        @(negedge clock);
        check("c2_valid", 64'(fetch_valid), 64'd1);
        check("c2_out", 64'(fetchoutput), 64'h12340000);
        @(negedge clock);
        check("c3_pc", 64'(fetch_pc), 64'd1);
        drain();

        // long instruction followed by a short one
        clear_mem();
        mem[0] = 16'h8001;
        mem[1] = 16'hABCD;
        mem[2] = 16'h0007;
        exp_push(32'h8001ABCD, 24'h0);
        exp_push(32'h00070000, 24'h2);
        do_reset(1'b0);
        repeat (3) @(negedge clock);
        check("long_c2_valid", 64'(fetch_valid), 64'd0);
        @(negedge clock);
        check("long_c3_valid", 64'(fetch_valid), 64'd1);
        check("long_c3_out", 64'(fetchoutput), 64'h8001ABCD);
        @(negedge clock);
        check("long_c4_pc", 64'(fetch_pc), 64'd2);
        drain();

        // ten cycles of stall: requests stop at a full buffer, nothing lost on release
        clear_mem();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 16'h0010 + 16'(i);
            exp_push({16'h0010 + 16'(i), 16'h0000}, PCW'(i));
        end
        do_reset(1'b1);
        repeat (4) @(negedge clock);
        check("stall_c3_req", 64'(imem_req), 64'd1);
        @(negedge clock);
        check("stall_c4_req", 64'(imem_req), 64'd0);
        repeat (5) @(negedge clock);
        check("stall_c9_req", 64'(imem_req), 64'd0);
        check("stall_c9_valid", 64'(fetch_valid), 64'd1);
        check("stall_c9_pc", 64'(fetch_pc), 64'd0);
        next_cycle();
        stall = 1'b0;
        drain();

        // branch during stall with a buffered halfword and a request in flight
        clear_mem();
        mem[0] = 16'h0777;
        mem[1] = 16'h0778;
        mem[9'h100] = 16'h0055;
        mem[9'h101] = 16'h8002;
        mem[9'h102] = 16'h3333;
        exp_push(32'h00550000, 24'h100);
        exp_push(32'h80023333, 24'h101);
        do_reset(1'b1);
        repeat (2) @(negedge clock);
        next_cycle();
        branch_taken = 1'b1;
        branch_target = 24'h000100;
        @(negedge clock);
        check("br_n_valid", 64'(fetch_valid), 64'd0);
        check("br_n_req", 64'(imem_req), 64'd0);
        next_cycle();
        branch_taken = 1'b0;
        stall = 1'b0;
        @(negedge clock);
        check("br_n1_req", 64'(imem_req), 64'd1);
        check("br_n1_addr", 64'(imem_addr), 64'h100);
        @(negedge clock);
        check("br_n2_valid", 64'(fetch_valid), 64'd0);
        @(negedge clock);
        check("br_n3_valid", 64'(fetch_valid), 64'd1);
        check("br_n3_pc", 64'(fetch_pc), 64'h100);
        drain();

        // branch while a long head has only its first halfword buffered
        clear_mem();
        mem[0] = 16'h8123;
        mem[1] = 16'h4567;
        mem[9'h180] = 16'h0099;
        mem[9'h181] = 16'h0001;
        exp_push(32'h00990000, 24'h180);
        exp_push(32'h00010000, 24'h181);
        do_reset(1'b0);
        repeat (2) @(negedge clock);
        next_cycle();
        branch_taken = 1'b1;
        branch_target = 24'h000180;
        @(negedge clock);
        check("half_n_valid", 64'(fetch_valid), 64'd0);
        next_cycle();
        branch_taken = 1'b0;
        @(negedge clock);
        check("half_n1_valid", 64'(fetch_valid), 64'd0);
        @(negedge clock);
        check("half_n2_valid", 64'(fetch_valid), 64'd0);
        @(negedge clock);
        check("half_n3_out", 64'(fetchoutput), 64'h00990000);
        drain();

        // reset asserted mid-stream
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0020 + 16'(i);
        exp_push(32'h00200000, 24'h0);
        exp_push(32'h00210000, 24'h1);
        exp_push(32'h00220000, 24'h2);
        do_reset(1'b0);
        repeat (5) @(negedge clock);
        check("mid_c4_valid", 64'(fetch_valid), 64'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("mid_rst_valid", 64'(fetch_valid), 64'd0);
        check("mid_rst_out", 64'(fetchoutput), 64'd0);
        check("mid_rst_pc", 64'(fetch_pc), 64'd0);
        check("mid_rst_req", 64'(imem_req), 64'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
